// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with CDB commit broadcast and mispredict/JALR flush.
module reorder_buffer #(
  parameter int ROB_CAP = 16,
  parameter int ROB_INDEX_BIT = 4,
  parameter int TYPE_BIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     inst_req,
  input  logic [TYPE_BIT-1:0]      inst_type,
  input  logic [4:0]               inst_rd,
  input  logic [31:0]              inst_addr,
  input  logic                     inst_pred_jump,
  input  logic [31:0]              inst_jump_addr,
  output logic [ROB_INDEX_BIT-1:0] alloc_rob_id,
  output logic                     full,
  input  logic                     rs_ready,
  input  logic [ROB_INDEX_BIT-1:0] rs_rob_id,
  input  logic [31:0]              rs_result,
  input  logic                     lsb_ready,
  input  logic [ROB_INDEX_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_result,
  input  logic [ROB_INDEX_BIT-1:0] query_id1,
  input  logic [ROB_INDEX_BIT-1:0] query_id2,
  output logic                     query_ready1,
  output logic                     query_ready2,
  output logic [31:0]              query_val1,
  output logic [31:0]              query_val2,
  output logic                     cdb_req,
  output logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
  output logic [31:0]              cdb_val,
  output logic [4:0]               commit_rd,
  output logic                     clear,
  output logic [31:0]              correct_pc
);
  // Type encoding shared with issue: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 branch, 5 load, 6 store, 7 ALU.
  localparam logic [TYPE_BIT-1:0] T_JALR = TYPE_BIT'(3);
  localparam logic [TYPE_BIT-1:0] T_BR = TYPE_BIT'(4);
  localparam logic [TYPE_BIT-1:0] T_ST = TYPE_BIT'(6);
  logic [ROB_INDEX_BIT-1:0] head, tail;
  logic [ROB_INDEX_BIT:0] count, next_count;
  logic [ROB_CAP-1:0] busy, ready;
  logic [TYPE_BIT-1:0] e_type [ROB_CAP];
  logic [4:0] e_rd [ROB_CAP];
  logic [31:0] e_addr [ROB_CAP];
  logic [31:0] e_jump [ROB_CAP];
  logic [31:0] e_val [ROB_CAP];
  logic [ROB_CAP-1:0] e_pred;
  logic commit, h_br, h_jalr, h_taken;
  logic [31:0] h_link;
  always_comb begin
    commit = ~clear & busy[head] & ready[head];
    next_count = count + (ROB_INDEX_BIT+1)'(inst_req) - (ROB_INDEX_BIT+1)'(commit);
    h_br = e_type[head] == T_BR;
    h_jalr = e_type[head] == T_JALR;
    h_taken = e_val[head][0];
    h_link = e_addr[head] + 32'd4;
  end
  assign alloc_rob_id = tail;
  // Same-cycle write-backs are forwarded, ALU path taking precedence.
  assign query_ready1 = (busy[query_id1] & ready[query_id1]) | (rs_ready & rs_rob_id == query_id1) | (lsb_ready & lsb_rob_id == query_id1);
  assign query_ready2 = (busy[query_id2] & ready[query_id2]) | (rs_ready & rs_rob_id == query_id2) | (lsb_ready & lsb_rob_id == query_id2);
  assign query_val1 = (rs_ready && rs_rob_id == query_id1) ? rs_result : (lsb_ready && lsb_rob_id == query_id1) ? lsb_result : e_val[query_id1];
  assign query_val2 = (rs_ready && rs_rob_id == query_id2) ? rs_result : (lsb_ready && lsb_rob_id == query_id2) ? lsb_result : e_val[query_id2];
  always_ff @(posedge clk_in)
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      busy <= '0;
      ready <= '0;
      full <= 1'b0;
      cdb_req <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val <= '0;
      commit_rd <= '0;
      clear <= 1'b0;
      correct_pc <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        busy <= '0;
        ready <= '0;
        full <= 1'b0;
        cdb_req <= 1'b0;
        clear <= 1'b0;
      end else begin
        if (inst_req) begin
          busy[tail] <= 1'b1;
          ready[tail] <= 1'b0;
          tail <= tail + 1'b1;
        end
        if (rs_ready) ready[rs_rob_id] <= 1'b1;
        if (lsb_ready) ready[lsb_rob_id] <= 1'b1;
        cdb_req <= commit;
        clear <= commit & (h_br ? h_taken != e_pred[head] : h_jalr);
        if (commit) begin
          busy[head] <= 1'b0;
          head <= head + 1'b1;
          cdb_rob_id <= head;
          cdb_val <= h_jalr ? h_link : e_val[head];
          commit_rd <= (h_br || e_type[head] == T_ST) ? 5'd0 : e_rd[head];
          correct_pc <= h_jalr ? e_val[head] & ~32'h1 : h_taken ? e_jump[head] : h_link;
        end
        count <= next_count;
        full <= next_count >= (ROB_INDEX_BIT+1)'(ROB_CAP - 2);
      end
    end
  always_ff @(posedge clk_in)
    if (rdy_in && !clear) begin
      if (inst_req) begin
        e_type[tail] <= inst_type;
        e_rd[tail] <= inst_rd;
        e_addr[tail] <= inst_addr;
        e_jump[tail] <= inst_jump_addr;
        e_pred[tail] <= inst_pred_jump;
      end
      if (rs_ready) e_val[rs_rob_id] <= rs_result;
      if (lsb_ready) e_val[lsb_rob_id] <= lsb_result;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of allocation, ordered commit, flush, forwarding and freeze.
module tb_reorder_buffer;
  localparam logic [2:0] T_JALR = 3'd3, T_BR = 3'd4, T_ALU = 3'd7;
  logic clk_in = 0, rst_in, rdy_in, inst_req, inst_pred_jump, rs_ready, lsb_ready;
  logic [2:0] inst_type;
  logic [4:0] inst_rd, commit_rd;
  logic [31:0] inst_addr, inst_jump_addr, rs_result, lsb_result, query_val1, query_val2, cdb_val, correct_pc;
  logic [3:0] alloc_rob_id, rs_rob_id, lsb_rob_id, query_id1, query_id2, cdb_rob_id;
  logic full, query_ready1, query_ready2, cdb_req, clear;
  int checks = 0, failures = 0;
  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .inst_req(inst_req), .inst_type(inst_type),
    .inst_rd(inst_rd), .inst_addr(inst_addr), .inst_pred_jump(inst_pred_jump), .inst_jump_addr(inst_jump_addr),
    .alloc_rob_id(alloc_rob_id), .full(full), .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_result(rs_result),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_result(lsb_result), .query_id1(query_id1),
    .query_id2(query_id2), .query_ready1(query_ready1), .query_ready2(query_ready2), .query_val1(query_val1),
    .query_val2(query_val2), .cdb_req(cdb_req), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .commit_rd(commit_rd), .clear(clear), .correct_pc(correct_pc)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic do_reset();
    rst_in = 1; rdy_in = 1; inst_req = 0; inst_type = T_ALU; inst_rd = 0; inst_addr = 0;
    inst_pred_jump = 0; inst_jump_addr = 0; rs_ready = 0; rs_rob_id = 0; rs_result = 0;
    lsb_ready = 0; lsb_rob_id = 0; lsb_result = 0; query_id1 = 0; query_id2 = 0;
    tick(); tick();
    rst_in = 0;
  endtask
  task automatic issue(input logic [2:0] t, input logic [4:0] rd, input logic [31:0] a, input logic pj, input logic [31:0] ja);
    inst_req = 1; inst_type = t; inst_rd = rd; inst_addr = a; inst_pred_jump = pj; inst_jump_addr = ja;
    tick();
    inst_req = 0;
  endtask
  task automatic wb_rs(input logic [3:0] id, input logic [31:0] r);
    rs_ready = 1; rs_rob_id = id; rs_result = r;
    tick();
    rs_ready = 0;
  endtask
  task automatic check_cdb(input string tag, input logic [3:0] id, input logic [31:0] v, input logic [4:0] rd);
    check({tag, "_req"}, cdb_req, 1);
    check({tag, "_id"}, cdb_rob_id, id);
    check({tag, "_val"}, cdb_val, v);
    check({tag, "_rd"}, commit_rd, rd);
  endtask
  initial begin
    do_reset();
    check("rst_full", full, 0);
    check("rst_cdb_req", cdb_req, 0);
    check("rst_cdb_val", cdb_val, 0);
    check("rst_commit_rd", commit_rd, 0);
    check("rst_clear", clear, 0);
    check("rst_correct_pc", correct_pc, 0);
    check("rst_alloc", alloc_rob_id, 0);
    // single ADDI commit latency
    issue(T_ALU, 5, 32'h0, 0, 0);
    check("addi_alloc_next", alloc_rob_id, 1);
    wb_rs(0, 7);
    check("addi_no_early", cdb_req, 0);
    tick();
    check_cdb("addi", 0, 7, 5);
    check("addi_no_clear", clear, 0);
    tick();
    check("addi_single_pulse", cdb_req, 0);
    // out-of-order write-back, in-order commit
    do_reset();
    issue(T_ALU, 1, 0, 0, 0);
    issue(T_ALU, 2, 4, 0, 0);
    issue(T_ALU, 3, 8, 0, 0);
    wb_rs(2, 32'h20);
    check("ooo_hold2", cdb_req, 0);
    wb_rs(1, 32'h10);
    check("ooo_hold1", cdb_req, 0);
    wb_rs(0, 32'h30);
    check("ooo_hold0", cdb_req, 0);
    tick();
    check_cdb("ooo_c0", 0, 32'h30, 1);
    tick();
    check_cdb("ooo_c1", 1, 32'h10, 2);
    tick();
    check_cdb("ooo_c2", 2, 32'h20, 3);
    tick();
    check("ooo_done", cdb_req, 0);
    // full threshold at count 14
    do_reset();
    for (int i = 0; i < 13; i++) issue(T_ALU, 4, 0, 0, 0);
    check("full_at13", full, 0);
    issue(T_ALU, 4, 0, 0, 0);
    check("full_at14", full, 1);
    check("full_alloc", alloc_rob_id, 14);
    wb_rs(0, 32'h1);
    check("full_wb_cycle", full, 1);
    tick();
    check("full_drop13", full, 0);
    check_cdb("full_c0", 0, 32'h1, 4);
    // BEQ mispredict flush, inst_req in flush cycle ignored
    do_reset();
    issue(T_BR, 0, 32'h100, 0, 32'h140);
    issue(T_ALU, 6, 32'h104, 0, 0);
    check("br_alloc2", alloc_rob_id, 2);
    wb_rs(0, 32'h1);
    tick();
    check("br_clear", clear, 1);
    check("br_pc", correct_pc, 32'h140);
    check("br_cdb_req", cdb_req, 1);
    check("br_rd0", commit_rd, 0);
    inst_req = 1;
    tick();
    inst_req = 0;
    check("br_clear_drop", clear, 0);
    check("br_no_cdb", cdb_req, 0);
    check("br_alloc0", alloc_rob_id, 0);
    check("br_full0", full, 0);
    tick();
    check("br_stays_quiet", cdb_req, 0);
    // correctly predicted taken branch does not flush
    issue(T_BR, 0, 32'h180, 1, 32'h1c0);
    wb_rs(0, 32'h1);
    tick();
    check("brok_cdb", cdb_req, 1);
    check("brok_no_clear", clear, 0);
    // JALR always flushes and links addr+4
    do_reset();
    issue(T_JALR, 1, 32'h200, 0, 0);
    wb_rs(0, 32'h301);
    tick();
    check_cdb("jalr", 0, 32'h204, 1);
    check("jalr_clear", clear, 1);
    check("jalr_pc", correct_pc, 32'h300);
    tick();
    check("jalr_clear_drop", clear, 0);
    // query forwarding, dual write-back, rdy freeze
    do_reset();
    for (int i = 0; i < 4; i++) issue(T_ALU, 5'(8 + i), 0, 0, 0);
    rs_ready = 1; rs_rob_id = 3; rs_result = 9; query_id1 = 3; query_id2 = 2;
    #1;
    check("q_fwd_ready", query_ready1, 1);
    check("q_fwd_val", query_val1, 9);
    check("q_not_ready", query_ready2, 0);
    tick();
    rs_ready = 0;
    check("q_reg_ready", query_ready1, 1);
    check("q_reg_val", query_val1, 9);
    rs_ready = 1; rs_rob_id = 0; rs_result = 32'hA;
    lsb_ready = 1; lsb_rob_id = 1; lsb_result = 32'hB;
    query_id1 = 0; query_id2 = 1;
    #1;
    check("q_rs_fwd", query_val1, 32'hA);
    check("q_lsb_fwd", query_val2, 32'hB);
    tick();
    rs_ready = 0; lsb_ready = 0;
    check("dual_ready0", query_ready1, 1);
    check("dual_ready1", query_ready2, 1);
    rdy_in = 0; inst_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_no_cdb", cdb_req, 0);
    end
    check("frz_no_alloc", alloc_rob_id, 4);
    rdy_in = 1; inst_req = 0;
    tick();
    check_cdb("frz_c0", 0, 32'hA, 8);
    tick();
    check_cdb("frz_c1", 1, 32'hB, 9);
    tick();
    check("frz_wait2", cdb_req, 0);
    wb_rs(2, 32'h22);
    tick();
    check_cdb("frz_c2", 2, 32'h22, 10);
    tick();
    check_cdb("frz_c3", 3, 9, 11);
    tick();
    check("frz_done", cdb_req, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue for the Tomasulo core. Allocates a ROB id per issued instruction, absorbs write-backs from the reservation station ALU path and the load/store buffer, and commits the head entry in program order. Each commit is broadcast on the CDB (rs/lsb/rf wake-up), writes the register file, and flushes the pipeline on a branch mispredict or JALR.

## Interface
Parameters:
- `ROB_CAP` (const.v), default 16: number of entries; power of two.
- `ROB_INDEX_BIT` (const.v), default 4: log2(`ROB_CAP`).
- `TYPE_BIT` (const.v): instruction type width; same encoding as the issue path.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  low freezes all state; outputs hold.
- inst_req  in  1  allocate one entry this cycle.
- inst_type  in  `TYPE_BIT`  instruction type.
- inst_rd  in  5  destination register; 0 means no write.
- inst_addr  in  32  instruction pc.
- inst_pred_jump  in  1  branch predicted taken.
- inst_jump_addr  in  32  branch taken target.
- alloc_rob_id  out  `ROB_INDEX_BIT`  id given to the instruction (= tail), combinational.
- full  out  1  registered; issue must not assert inst_req while high.
- rs_ready, rs_rob_id, rs_result  in  1/`ROB_INDEX_BIT`/32  ALU write-back.
- lsb_ready, lsb_rob_id, lsb_result  in  1/`ROB_INDEX_BIT`/32  load/store write-back.
- query_id1, query_id2  in  `ROB_INDEX_BIT`  operand lookups from rf.
- query_ready1/2, query_val1/2  out  1/32  combinational: entry ready and its value.
- cdb_req, cdb_rob_id, cdb_val  out  1/`ROB_INDEX_BIT`/32  registered commit broadcast.
- commit_rd  out  5  registered; rf writes cdb_val when cdb_req and commit_rd != 0.
- clear  out  1  registered flush pulse.
- correct_pc  out  32  registered; valid with clear.

## Operation
- Circular queue: head, tail, count (0..`ROB_CAP`). Per-entry fields: busy, ready, type, rd, addr, pred_jump, jump_addr, val.
- Allocate on inst_req at tail: busy=1, tail++ mod `ROB_CAP`.
  - JAL/LUI/AUIPC/ALU/branch/JALR/load: ready=0.
  - Store: ready=0; becomes ready via lsb write-back (address/data captured).
- Write-back: rs_ready or lsb_ready sets ready=1 and val=result for that id. Both in one cycle to different ids: both apply.
- Commit when the head is busy and ready; one commit per cycle max.
  - Register types: cdb_val=val, commit_rd=rd.
  - Branch: commit_rd=0. Actual taken = val[0]. If it differs from pred_jump: clear=1, correct_pc = taken ? jump_addr : addr+4.
  - JALR: cdb_val = addr+4, commit_rd=rd, clear=1, correct_pc = val & ~32'h1 (always flush).
  - Store: commit_rd=0; the cdb_req broadcast tells lsb to perform the write.
  - Commit: busy=0, head++ mod `ROB_CAP`.
- Query ports: query_ready = busy && ready of that entry, or a same-cycle cdb write-back hit on that id (then val forwarded from the write-back bus, rs before lsb).
- Arithmetic: 32-bit wrap on addr+4; index wrap mod `ROB_CAP` by width truncation.

## Timing
- Reset: head=tail=count=0, all busy=0, full=0, cdb_req=0, cdb_rob_id=0, cdb_val=0, commit_rd=0, clear=0, correct_pc=0.
- Write-back at cycle t → ready visible at t+1. Commit decided at t+1 → cdb_*/commit_rd/clear valid during t+2, one cycle only.
- next_count = count + inst_req − commit. full <= (next_count >= `ROB_CAP` − 2). The 2 spare entries cover the issue register latency.
- Allocation and commit in the same cycle are both honoured; count is unchanged.
- clear high during cycle t: at the t edge all entries, head, tail, count, and full go to 0. inst_req and write-backs in that cycle are ignored. clear drops next cycle. cdb_req is not asserted in the flush cycle.
- rdy_in low: no allocation, write-back, or commit; registered outputs hold (no repeated commit effect).
- rst_in has priority over rdy_in and clear.

## Test plan
- Reset, then issue ADDI rd=5 (id 0). At cycle 3, rs_ready with id 0, result 7 → cdb_req=1, cdb_rob_id=0, cdb_val=7, commit_rd=5 exactly two cycles later; single pulse.
- Issue ids 0,1,2. Write back 2, then 1, then 0 → commits appear in order 0,1,2 on consecutive cycles.
- Issue 14 entries with no write-back → full=1 after the edge that brings count to 14; a concurrent commit drops count to 13 and full deasserts.
- BEQ at addr 0x100, pred_jump=0, jump_addr 0x140; write-back val=1 → clear=1, correct_pc=0x140. Next cycle count=0, alloc_rob_id=0.
- JALR at addr 0x200, rd=1; write-back 0x301 → cdb_val=0x204, commit_rd=1, clear=1, correct_pc=0x300.
- query_id1=3 in the same cycle as rs_ready id 3, result 9 → query_ready1=1, query_val1=9. Hold rdy_in low 3 cycles mid-stream → no cdb_req pulses, and state resumes intact afterwards.
